// File: rtl/uart_tx_model.sv
// uart_tx_model: bench-side UART transmitter.
// Bytes pushed by the bench are buffered in a small FIFO and serialised on txd as
// asynchronous frames: start bit, 5-8 data bits LSB first, optional even parity,
// then 1-2 stop bits. Frame format is latched when each frame starts.
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit after the data.
module uart_tx_model #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   ctrl_baud_clks,
  input  logic [3:0]                    ctrl_bits,
  input  logic [1:0]                    ctrl_stops,
  input  logic                          tx_valid,
  input  logic [7:0]                    tx_data,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam logic [AddrW:0] FullCount = (AddrW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AddrW-1:0] r_wr_ptr;
  logic [AddrW-1:0] r_rd_ptr;
  logic [AddrW:0]   r_count;

  // Serialiser state
  state_e      r_state;
  logic        r_txd;
  logic        r_busy;
  logic [31:0] r_clk_cnt;
  logic [2:0]  r_bit_idx;
  logic        r_stop_cnt;
  logic [7:0]  r_shift;
  logic [31:0] r_baud;
  logic [3:0]  r_bits;
  logic        r_two_stops;
`ifdef UART_TX_PARITY_EN
  logic        r_parity;
  logic        w_parity;
`endif

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_bit_end;
  logic        w_last_stop;
  logic [31:0] w_baud;
  logic [3:0]  w_bits;
  logic        w_two_stops;
  logic [7:0]  w_mask;
  logic [7:0]  w_head_masked;

  // FIFO flags, frame-format normalisation and pop decision
  always_comb begin
    w_full        = (r_count == FullCount);
    w_empty       = (r_count == '0);
    w_push        = tx_valid & ~w_full;
    w_baud        = (ctrl_baud_clks == 32'd0) ? 32'd1 : ctrl_baud_clks;
    w_bits        = (ctrl_bits < 4'd5) ? 4'd5 : ((ctrl_bits > 4'd8) ? 4'd8 : ctrl_bits);
    w_two_stops   = (ctrl_stops >= 2'd2);
    w_mask        = 8'hFF >> (4'd8 - w_bits);
    w_head_masked = r_mem[r_rd_ptr] & w_mask;
    w_bit_end     = (r_clk_cnt == r_baud - 32'd1);
    w_last_stop   = (r_state == StStop) && w_bit_end && (r_stop_cnt == r_two_stops);
    // A new frame starts from idle, or directly on the edge ending the last stop bit
    w_pop         = ~w_empty && ((r_state == StIdle) || w_last_stop);
`ifdef UART_TX_PARITY_EN
    w_parity      = ^w_head_masked;
`endif
  end

  // FIFO write port (storage needs no reset; occupancy guards reads)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame FSM with registered line and busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_txd       <= 1'b1;
      r_busy      <= 1'b0;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_stop_cnt  <= 1'b0;
      r_shift     <= '0;
      r_baud      <= 32'd1;
      r_bits      <= 4'd8;
      r_two_stops <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else if (w_pop) begin
      // Enter START: load the byte and freeze the format for this frame
      r_state     <= StStart;
      r_txd       <= 1'b0;
      r_busy      <= 1'b1;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_stop_cnt  <= 1'b0;
      r_shift     <= w_head_masked;
      r_baud      <= w_baud;
      r_bits      <= w_bits;
      r_two_stops <= w_two_stops;
`ifdef UART_TX_PARITY_EN
      r_parity    <= w_parity;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          r_txd  <= 1'b1;
          r_busy <= 1'b0;
        end
        StStart: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_state   <= StData;
            r_txd     <= r_shift[0];
          end else begin
            r_clk_cnt <= r_clk_cnt + 32'd1;
          end
        end
        StData: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_shift   <= r_shift >> 1;
            if ({1'b0, r_bit_idx} == r_bits - 4'd1) begin
`ifdef UART_TX_PARITY_EN
              r_state    <= StParity;
              r_txd      <= r_parity;
`else
              r_state    <= StStop;
              r_txd      <= 1'b1;
              r_stop_cnt <= 1'b0;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_txd     <= r_shift[1];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 32'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (w_bit_end) begin
            r_clk_cnt  <= '0;
            r_state    <= StStop;
            r_txd      <= 1'b1;
            r_stop_cnt <= 1'b0;
          end else begin
            r_clk_cnt <= r_clk_cnt + 32'd1;
          end
        end
`endif
        StStop: begin
          r_txd <= 1'b1;
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (w_last_stop) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 32'd1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready = ~w_full;
  assign txd      = r_txd;
  assign tx_busy  = r_busy;
  assign tx_level = r_count;

endmodule

// File: tb/tb_uart_tx_model.sv
// Self-checking bench for uart_tx_model: a serial-line monitor decodes frames and
// compares them against a queue of bytes recorded when they were pushed.
module tb_uart_tx_model;

`ifdef UART_TX_PARITY_EN
  localparam int Par = 1;
`else
  localparam int Par = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] ctrl_baud_clks;
  logic [3:0]  ctrl_bits;
  logic [1:0]  ctrl_stops;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        txd;
  logic        tx_busy;
  logic [2:0]  tx_level;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          push_cyc = 0;
  logic [7:0]  exp_q [$];
  int          waits [6];
  int          starts [6];

  uart_tx_model #(.FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ctrl_baud_clks (ctrl_baud_clks),
    .ctrl_bits      (ctrl_bits),
    .ctrl_stops     (ctrl_stops),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .txd            (txd),
    .tx_busy        (tx_busy),
    .tx_level       (tx_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mask_of(input int nbits);
    logic [7:0] m;
    m = 8'hFF;
    return m >> (8 - nbits);
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [7:0] d, input int nbits, output int waited);
    waited   = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    while (!tx_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!tx_ready) check("send_ready_timeout", 32'(tx_ready), 32'd1);
    else exp_q.push_back(d & mask_of(nbits));
    @(negedge clk);
    push_cyc = cyc;
    tx_valid = 1'b0;
  endtask

  // Waits for a start bit, samples every clock of the frame and scores it.
  task automatic recv(input int b, input int nb, input int ns, output int t0);
    int         n;
    int         glitch;
    int         stop_ones;
    logic       v;
    logic [15:0] seq;
    logic [7:0] d;
    logic [7:0] e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (txd !== 1'b0 && n < 5000);
    t0 = cyc;
    if (txd !== 1'b0) begin
      check("start_timeout", 32'(txd), 32'd0);
      return;
    end
    check("busy_in_frame", 32'(tx_busy), 32'd1);
    glitch = 0;
    seq    = '0;
    for (int i = 0; i < 1 + nb + Par + ns; i++) begin
      if (i != 0) @(negedge clk);
      v = txd;
      for (int k = 1; k < b; k++) begin
        @(negedge clk);
        if (txd !== v) glitch++;
      end
      seq[i] = v;
    end
    d = '0;
    for (int i = 0; i < nb; i++) d[i] = seq[1 + i];
    stop_ones = 0;
    for (int j = 0; j < ns; j++) if (seq[1 + nb + Par + j] === 1'b1) stop_ones++;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'(d), 32'hFFFF);
      e = 8'h00;
    end else begin
      e = exp_q.pop_front();
      check("data", 32'(d), 32'(e));
    end
`ifdef UART_TX_PARITY_EN
    check("parity", 32'(seq[1 + nb]), 32'(^e));
`endif
    check("stop_bits", 32'(stop_ones), 32'(ns));
    check("bit_hold", 32'(glitch), 32'd0);
  endtask

  initial begin
    int w;
    int t0;
    int t1;
    int act;
    rst_n          = 1'b0;
    ctrl_baud_clks = 32'd2;
    ctrl_bits      = 4'd8;
    ctrl_stops     = 2'd1;
    tx_valid       = 1'b0;
    tx_data        = 8'h00;
    repeat (4) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_level", 32'(tx_level), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame, B=2, 8N1, 0xA5
    send(8'hA5, 8, w);
    check("a_level_after_push", 32'(tx_level), 32'd1);
    check("a_busy_before_start", 32'(tx_busy), 32'd0);
    recv(2, 8, 1, t0);
    check("a_start_latency", 32'(t0 - push_cyc), 32'd1);
    @(negedge clk);
    check("a_frame_len", 32'(cyc - t0), 32'(2 * (10 + Par)));
    check("a_busy_end", 32'(tx_busy), 32'd0);
    check("a_level_end", 32'(tx_level), 32'd0);
    check("a_txd_idle", 32'(txd), 32'd1);

    // Six back-to-back bytes through a 4-deep FIFO
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(8'(i + 1), 8, waits[i]);
          if (i == 4) begin
            check("b_level_full", 32'(tx_level), 32'd4);
            check("b_ready_full", 32'(tx_ready), 32'd0);
          end
        end
      end
      begin
        for (int i = 0; i < 6; i++) recv(2, 8, 1, starts[i]);
      end
    join
    check("b_5th_no_wait", 32'(waits[4]), 32'd0);
    check("b_6th_waited", 32'(waits[5] > 0), 32'd1);
    for (int i = 1; i < 6; i++) check("b_gap", 32'(starts[i] - starts[i - 1]), 32'(2 * (10 + Par)));
    @(negedge clk);
    check("b_level_end", 32'(tx_level), 32'd0);
    check("b_busy_end", 32'(tx_busy), 32'd0);

    // 5 data bits, 2 stops, B=3; format changed mid-frame must not affect it
    ctrl_baud_clks = 32'd3;
    ctrl_bits      = 4'd5;
    ctrl_stops     = 2'd2;
    send(8'hFF, 5, w);
    fork
      recv(3, 5, 2, t0);
      begin
        @(negedge clk);
        ctrl_baud_clks = 32'd7;
        ctrl_bits      = 4'd8;
        ctrl_stops     = 2'd0;
      end
    join
    @(negedge clk);
    check("c_frame_len", 32'(cyc - t0), 32'(3 * (8 + Par)));
    check("c_busy_end", 32'(tx_busy), 32'd0);
    check("c_txd_idle", 32'(txd), 32'd1);

    // Normalisation: baud 0 -> 1, bits 12 -> 8, stops 0 -> 1
    ctrl_baud_clks = 32'd0;
    ctrl_bits      = 4'd12;
    ctrl_stops     = 2'd0;
    fork
      begin
        send(8'h07, 8, w);
        send(8'h03, 8, w);
      end
      begin
        recv(1, 8, 1, t0);
        recv(1, 8, 1, t1);
      end
    join
    check("d_gap", 32'(t1 - t0), 32'(10 + Par));

    // Reset in the 4th data bit of 0x00 with two bytes queued
    ctrl_baud_clks = 32'd2;
    ctrl_bits      = 4'd8;
    ctrl_stops     = 2'd1;
    repeat (3) @(negedge clk);
    send(8'h00, 8, w);
    send(8'h11, 8, w);
    send(8'h22, 8, w);
    check("e_level_queued", 32'(tx_level), 32'd2);
    repeat (7) @(negedge clk);
    check("e_txd_bit3", 32'(txd), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("e_rst_txd", 32'(txd), 32'd1);
    check("e_rst_level", 32'(tx_level), 32'd0);
    check("e_rst_busy", 32'(tx_busy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    repeat (40) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_busy !== 1'b0 || tx_level !== 3'd0) act++;
    end
    check("e_quiet_after_rst", 32'(act), 32'd0);
    send(8'h5A, 8, w);
    recv(2, 8, 1, t0);
    @(negedge clk);
    check("e_busy_end", 32'(tx_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
